// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier, restoring divider, registered result.
// Define RISCV_MULDIV_FAST_MUL_EN to replace the iterative multiplier with a single-cycle one.
module riscv_muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     m_q, rem_q, quo_q, result_q;
  logic [2*XLEN-1:0]   prod_q;
  logic                q_neg_q, r_neg_q;

  logic                accept, is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic                div_zero, div_ovf, special, last;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       add_sum, rem_shift, rem_diff;
  logic [2*XLEN-1:0]   prod_step, prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix, fix_res;

  assign accept   = start & ~flush & ((state_q == StIdle) | (state_q == StDone));
  assign is_div   = funct3[2];
  assign a_sgn    = (funct3 == 3'b001) | (funct3 == 3'b010) | (is_div & ~funct3[0]);
  assign b_sgn    = (funct3 == 3'b001) | (is_div & ~funct3[0]);
  assign a_neg    = a_sgn & SrcA[XLEN-1];
  assign b_neg    = b_sgn & SrcB[XLEN-1];
  assign a_mag    = a_neg ? -SrcA : SrcA;
  assign b_mag    = b_neg ? -SrcB : SrcB;
  assign div_zero = (SrcB == '0);
  assign div_ovf  = is_div & ~funct3[0] & (SrcA == MinNeg) & (SrcB == '1);
  assign special  = is_div & (div_zero | div_ovf);
  assign last     = (cnt_q == CNT_W'(XLEN - 1));

  // One multiplier bit per cycle: conditionally add, then shift the product right.
  assign add_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, m_q} : '0);
  assign prod_step = {add_sum, prod_q[XLEN-1:1]};
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, m_q};

  assign prod_fix = q_neg_q ? -prod_q : prod_q;
  assign quo_fix  = q_neg_q ? -quo_q : quo_q;
  assign rem_fix  = r_neg_q ? -rem_q : rem_q;

  always_comb begin
    fix_res = rem_fix;
    case (op_q)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          if (special)     state_d = StFix;
          else if (is_div) state_d = StDiv;
          else begin
`ifdef RISCV_MULDIV_FAST_MUL_EN
            state_d = StFix;
`else
            state_d = StMul;
`endif
          end
        end
      end
      StMul, StDiv: if (last) state_d = StFix;
      StFix:        state_d = StDone;
      default:      state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_comb begin
    busy   = (state_q != StIdle);
    done   = (state_q == StDone);
    result = result_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      op_q     <= '0;
      m_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      prod_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= funct3;
        cnt_q   <= '0;
        q_neg_q <= a_neg ^ b_neg;
        r_neg_q <= a_neg;
        rem_q   <= '0;
        if (is_div) begin
          m_q   <= b_mag;
          quo_q <= a_mag;
          // Overflow needs no override: |MinNeg| is MinNeg and both signs cancel.
          if (div_zero) begin
            quo_q   <= '1;
            rem_q   <= a_mag;
            q_neg_q <= 1'b0;
          end
        end else begin
          m_q <= a_mag;
`ifdef RISCV_MULDIV_FAST_MUL_EN
          prod_q <= {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`else
          prod_q <= {{XLEN{1'b0}}, b_mag};
`endif
        end
      end else if (state_q == StMul) begin
        prod_q <= prod_step;
        cnt_q  <= cnt_q + 1'b1;
      end else if (state_q == StDiv) begin
        if (!rem_diff[XLEN]) begin
          rem_q <= rem_diff[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_q <= rem_shift[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_q <= cnt_q + 1'b1;
      end
      if ((state_q == StFix) && !flush) result_q <= fix_res;
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Self-checking bench for riscv_muldiv_unit: directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_riscv_muldiv_unit;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] SrcA, SrcB;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  // Edges from the accepting edge to the edge that raises done.
  function automatic int ref_edges(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
`ifdef RISCV_MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return XLEN + 1;
  endfunction

  // Entered #1 after the accepting edge; returns #1 after the edge that raised done.
  task automatic wait_done(input string tag, input int exp_edges, input logic [31:0] exp_res);
    int edges = 0;
    bit busy_ok = 1'b1;
    while (done !== 1'b1 && edges < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_lat"}, 64'(edges), 64'(exp_edges));
    check({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd1);
    check({tag, "_res"}, 64'(result), 64'(exp_res));
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp_res;
    exp_res = ref_res(f, a, b);
    @(negedge clk);
    start = 1'b1; funct3 = f; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(tag, ref_edges(f, a, b), exp_res);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_hold"}, 64'(result), 64'(exp_res));
  endtask

  initial begin
    logic [31:0] prior, a, b;
    logic [2:0]  f;
    bit          saw_done;

    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; SrcA = '0; SrcB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    reset = 1'b0;

    run_op("mul_neg", 3'd0, 32'd7, 32'hFFFFFFFD);
    run_op("mulh_min", 3'd1, 32'h80000000, 32'h80000000);
    run_op("mulhu_min", 3'd3, 32'h80000000, 32'h80000000);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2);
    run_op("div_neg", 3'd4, 32'hFFFFFFF9, 32'd2);
    run_op("rem_neg", 3'd6, 32'hFFFFFFF9, 32'd2);
    run_op("divu", 3'd5, 32'd100, 32'd7);
    run_op("remu", 3'd7, 32'd100, 32'd7);
    run_op("divu_z", 3'd5, 32'h1234, 32'd0);
    run_op("remu_z", 3'd7, 32'h1234, 32'd0);
    run_op("div_z_neg", 3'd4, 32'hFFFFFF00, 32'd0);
    run_op("rem_z_neg", 3'd6, 32'hFFFFFF00, 32'd0);
    run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF);
    run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF);
    run_op("mul7x3", 3'd0, 32'd7, 32'd3);

    // Flush mid-DIV: op dropped, result keeps prior value.
    prior = result;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; SrcA = 32'd1000; SrcB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    check("flush_result", 64'(result), 64'(prior));
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("flush_no_done", 64'(saw_done), 64'd0);
    run_op("after_flush", 3'd4, 32'd1000, 32'd3);

    // Flush and start together in IDLE: start is dropped.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; SrcA = 32'd5; SrcB = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);

    // Start pulsed mid-op is ignored.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; SrcA = 32'd12345; SrcB = 32'd678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; funct3 = 3'd5; SrcA = 32'd1; SrcB = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ign_start", XLEN + 1 - 6, ref_res(3'd0, 32'd12345, 32'd678));

    // Back-to-back: start held in the DONE cycle, no idle bubble.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; SrcA = 32'd100; SrcB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("b2b_first", XLEN + 1, 32'd14);
    start = 1'b1; funct3 = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_no_bubble", 64'(busy), 64'd1);
    check("b2b_done_low", 64'(done), 64'd0);
    wait_done("b2b_second", XLEN + 1, 32'd2);

    // Reset mid-DIV clears everything and suppresses done.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; SrcA = 32'd999; SrcB = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_done", 64'(done), 64'd0);
    check("rstmid_result", 64'(result), 64'd0);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("rstmid_no_done", 64'(saw_done), 64'd0);

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3: b = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: ;
      endcase
      run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
